// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: applies branch redirects, holds redirects across
// stalls, traps on illegal targets and keeps saturating branch statistics.
module pc_redirect_ctrl #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Branch,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  output logic [PC_W-1:0]  Cur_PC,
  output logic             Flush,
  output logic             Trap,
  output logic             PendValid,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount
);

  typedef enum logic [1:0] {
    RUN,
    PEND,
    TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_d;
  logic [PC_W-1:0]  pend_q, pend_d;
  logic             illegal;
  logic             flush_c;
  logic             inc_branch;
  logic             inc_taken;

  assign illegal = (|BrPC[1:0]) || (|BrPC[31:PC_W]);

  always_comb begin
    state_d    = state_q;
    pc_d       = Cur_PC;
    pend_d     = pend_q;
    flush_c    = 1'b0;
    inc_branch = 1'b0;
    inc_taken  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!Stall) begin
          inc_branch = Branch;
          if (!PcSel) begin
            pc_d = Cur_PC + PC_W'(4);
          end else if (illegal) begin
            state_d = TRAP;
          end else begin
            pc_d      = BrPC[PC_W-1:0];
            flush_c   = 1'b1;
            inc_taken = 1'b1;
          end
        end else if (PcSel) begin
          if (illegal) begin
            state_d = TRAP;
          end else begin
            pend_d     = BrPC[PC_W-1:0];
            state_d    = PEND;
            inc_taken  = 1'b1;
            inc_branch = Branch;
          end
        end
      end
      PEND: begin
        if (!Stall) begin
          pc_d    = pend_q;
          flush_c = 1'b1;
          state_d = RUN;
        end
      end
      TRAP: begin
        flush_c = 1'b1;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

  // Reset overrides the combinational flush so nothing is squashed in reset.
  assign Flush     = flush_c & ~reset;
  assign Trap      = (state_q == TRAP);
  assign PendValid = (state_q == PEND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      Cur_PC      <= '0;
      pend_q      <= '0;
      BranchCount <= '0;
      TakenCount  <= '0;
    end else begin
      state_q <= state_d;
      Cur_PC  <= pc_d;
      pend_q  <= pend_d;
      if (inc_branch && (BranchCount != '1))
        BranchCount <= BranchCount + 1'b1;
      if (inc_taken && (TakenCount != '1))
        TakenCount <= TakenCount + 1'b1;
    end
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Owns the fetch PC register and sequences it from branch-resolution results: PcSel/BrPC from the EX-stage branch logic and Stall from the hazard unit.
- Generates the pipeline Flush and holds a redirect that arrives while the pipe is stalled.
- Traps on illegal branch targets.
- Keeps saturating branch/taken statistics counters.
- Sits between the branch logic, the hazard unit and instruction memory.

Parameters:
PC_W, 9, width of Cur_PC (instruction memory byte address)
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
Stall  input  1  hazard unit: hold PC, do not accept branch events
Branch  input  1  instruction in EX is a conditional branch (statistics only)
PcSel  input  1  branch/jump in EX is taken
BrPC  input  32  taken target byte address
Cur_PC  output  PC_W  current fetch PC
Flush  output  1  bubble IF/ID and ID/EX at next edge
Trap  output  1  illegal target seen; sticky until reset
PendValid  output  1  redirect captured while stalled, not yet applied
BranchCount  output  CNT_W  accepted Branch events, saturating
TakenCount  output  CNT_W  applied or captured taken events, saturating

Behaviour:
- Reset (async, any state, any time): Cur_PC=0, state=RUN, PendPC=0, BranchCount=0, TakenCount=0.
  - Trap=0, PendValid=0, Flush=0 while reset is asserted.
- States: RUN, PEND, TRAP.
- Illegal target:
  - BrPC[1:0]!=0 (misaligned), or
  - BrPC[31:PC_W]!=0 (out of range).
- RUN, Stall=0:
  - PcSel=0: Cur_PC <= Cur_PC+4, modulo 2^PC_W (wraps to 0); Flush=0.
  - PcSel=1, legal target: Cur_PC <= BrPC[PC_W-1:0]; Flush=1 (combinational, same cycle); TakenCount+1.
  - PcSel=1, illegal target: -> TRAP; Cur_PC unchanged; TakenCount unchanged.
  - Branch=1: BranchCount+1, including the illegal-target case.
- RUN, Stall=1:
  - PcSel=0: Cur_PC holds; no counting; Flush=0.
  - PcSel=1, legal target: PendPC <= BrPC[PC_W-1:0]; -> PEND; TakenCount+1; BranchCount+1 if Branch=1; Flush=0.
  - PcSel=1, illegal target: -> TRAP.
- PEND:
  - PendValid=1.
  - PcSel, BrPC and Branch are ignored; no counting.
  - Stall=1: Cur_PC holds; Flush=0.
  - Stall=0: Cur_PC <= PendPC; Flush=1 this cycle; -> RUN.
- TRAP:
  - Trap=1 and Flush=1 every cycle.
  - Cur_PC and counters frozen; all inputs ignored.
  - Exit only via reset.
- Flush is purely combinational from state, Stall, PcSel and BrPC. All other outputs are registered.
- Counters saturate at 2^CNT_W-1; no wrap.
- Latency: a redirect accepted in cycle N presents the new Cur_PC in cycle N+1. One wrong-path fetch is squashed by Flush.

Test Plan:
- Reset then 5 cycles Stall=0, PcSel=0 -> Cur_PC = 0,4,8,12,16; Flush=0; counters 0.
- Cur_PC=0x10, Branch=1, PcSel=1, BrPC=0x40, Stall=0 -> Flush=1 same cycle; next Cur_PC=0x40; BranchCount=1, TakenCount=1.
- Stall=1 with PcSel=1, BrPC=0x80 for 3 cycles, then Stall=0:
  - PendValid=1 from cycle 2; Cur_PC held; Flush=0 while stalled.
  - Flush=1 on the release cycle; then Cur_PC=0x80; TakenCount +1 exactly once.
- PcSel=1 with BrPC=0x42 (misaligned) or BrPC=0x200 at PC_W=9:
  - Trap=1 and Flush=1 from the next cycle; Cur_PC frozen for 10 cycles.
  - Async reset pulse mid-cycle clears Trap and sets Cur_PC=0 immediately.
- Cur_PC=0x1FC, PcSel=0 -> next Cur_PC=0x000 (wrap).
- CNT_W=2, 5 accepted taken branches -> TakenCount saturates at 3.
